cpu_multicycle: RTL and testbench

CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

---
 rtl/cpu_mc_pkg.sv | 43 ++++
 rtl/cpu_mc_alu.sv | 30 +++
 rtl/cpu_multicycle.sv | 140 ++++++++++++++
 tb/tb_cpu_multicycle.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multicycle CPU: opcodes, FSM states and
// instruction field positions.
package cpu_mc_pkg;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned REG_AW   = 3;
    localparam int unsigned OPC_W    = 4;
    localparam int unsigned IMM_W    = 8;

    // Instruction field LSB positions
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_LSB  = 9;
    localparam int unsigned RS1_LSB = 6;
    localparam int unsigned RS2_LSB = 3;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SHL   = 4'd5,
        OP_SHR   = 4'd6,
        OP_MOV   = 4'd7,
        OP_LDI   = 4'd8,
        OP_BEQZ  = 4'd9,
        OP_JMP   = 4'd10,
        OP_NOP11 = 4'd11,
        OP_NOP12 = 4'd12,
        OP_NOP13 = 4'd13,
        OP_NOP14 = 4'd14,
        OP_HALT  = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

endpackage

// File: rtl/cpu_mc_alu.sv
// Combinational ALU for register-register ops (opcodes 0..7).
// Ports: op - opcode, a - rs1 operand, b - rs2 operand, y - result.
// Non-ALU opcodes produce zero.
module cpu_mc_alu
    import cpu_mc_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  opcode_e             op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [DATA_W-1:0]   y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SHL:  y = {a[DATA_W-2:0], 1'b0};
            OP_SHR:  y = {1'b0, a[DATA_W-1:1]};
            OP_MOV:  y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/cpu_multicycle.sv
// Multicycle CPU core: FETCH/EXEC/HALT FSM, 8-entry register file, PC.
// Ports:
//   clk, rst_n         - clock, async active-low reset
//   imem_req/imem_addr - fetch request and address (PC), held until accepted
//   imem_valid/data    - fetch response; valid accepts the request in FETCH
//   retire             - one-cycle pulse during each EXEC
//   halted             - core stopped after HALT, leaves only via reset
//   dbg_raddr/rdata    - combinational register debug read
// Config macro: CPU_MULTICYCLE_R0_ZERO_EN makes r0 hardwired to zero.
module cpu_multicycle
    import cpu_mc_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PC_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_valid,
    input  logic [INSTR_W-1:0]  imem_data,
    output logic                retire,
    output logic                halted,
    input  logic [REG_AW-1:0]   dbg_raddr,
    output logic [DATA_W-1:0]   dbg_rdata
);

`ifdef CPU_MULTICYCLE_R0_ZERO_EN
    localparam logic R0_ZERO = 1'b1;
`else
    localparam logic R0_ZERO = 1'b0;
`endif

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]    regs_q [NUM_REGS];
    logic                 retire_q, retire_d;
    logic                 halted_q, halted_d;
    logic                 req_q;

    opcode_e              op;
    logic [REG_AW-1:0]    rd, rs1, rs2;
    logic [IMM_W-1:0]     imm;
    logic [DATA_W-1:0]    rd_val, rs1_val, rs2_val, alu_y, wr_data;
    logic                 wr_en, wr_en_eff;

    // Instruction field decode
    assign op  = opcode_e'(ir_q[OPC_LSB +: OPC_W]);
    assign rd  = ir_q[RD_LSB  +: REG_AW];
    assign rs1 = ir_q[RS1_LSB +: REG_AW];
    assign rs2 = ir_q[RS2_LSB +: REG_AW];
    assign imm = ir_q[IMM_LSB +: IMM_W];

    // Operand reads see pre-write values, so rd==rs uses the old value
    assign rd_val  = (R0_ZERO && rd  == '0) ? '0 : regs_q[rd];
    assign rs1_val = (R0_ZERO && rs1 == '0) ? '0 : regs_q[rs1];
    assign rs2_val = (R0_ZERO && rs2 == '0) ? '0 : regs_q[rs2];
    assign dbg_rdata = (R0_ZERO && dbg_raddr == '0) ? '0 : regs_q[dbg_raddr];

    cpu_mc_alu #(.DATA_W(DATA_W)) u_alu (
        .op (op),
        .a  (rs1_val),
        .b  (rs2_val),
        .y  (alu_y)
    );

    // Next-state, PC update and writeback selection
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        retire_d = 1'b0;
        halted_d = halted_q;
        wr_en    = 1'b0;
        wr_data  = alu_y;
        case (state_q)
            ST_FETCH: begin
                if (imem_valid) begin
                    ir_d     = imem_data;
                    state_d  = ST_EXEC;
                    retire_d = 1'b1;  // retire is high for the whole EXEC cycle
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_q + PC_W'(1);
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_XOR, OP_SHL, OP_SHR, OP_MOV: wr_en = 1'b1;
                    OP_LDI: begin
                        wr_en   = 1'b1;
                        wr_data = DATA_W'(imm);
                    end
                    OP_BEQZ: begin
                        if (rd_val == '0) pc_d = PC_W'(imm);
                    end
                    OP_JMP:  pc_d = PC_W'(imm);
                    OP_HALT: begin
                        pc_d     = pc_q;
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    assign wr_en_eff = wr_en && !(R0_ZERO && rd == '0);

    // State, PC, IR, register file and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            retire_q <= 1'b0;
            halted_q <= 1'b0;
            req_q    <= 1'b1;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            retire_q <= retire_d;
            halted_q <= halted_d;
            req_q    <= (state_d == ST_FETCH);
            if (wr_en_eff) regs_q[rd] <= wr_data;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign retire    = retire_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Scoreboard bench for cpu_multicycle: a program-level reference model
// predicts the retire sequence; a memory responder injects stalls and a
// monitor checks fetch address, retire spacing and register contents.
`timescale 1ns/1ps
module tb_cpu_multicycle;

    localparam int DATA_W = 8;
    localparam int PC_W   = 8;
    localparam int MASK   = (1 << DATA_W) - 1;
    localparam logic [15:0] HALT_INS = 16'hF000;
`ifdef CPU_MULTICYCLE_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_valid = 1'b0;
    logic [15:0]       imem_data = '0;
    logic              retire;
    logic              halted;
    logic [2:0]        dbg_raddr = '0;
    logic [DATA_W-1:0] dbg_rdata;

    cpu_multicycle #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .retire     (retire),
        .halted     (halted),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { int pc; int rd; int val; } exp_t;
    typedef struct { int addr; int stall; } acc_t;

    exp_t        exp_q[$];
    acc_t        acc_q[$];
    logic [15:0] mem [256];
    int          checks = 0;
    int          failures = 0;
    int          stall_mode = 0;
    bit          sb_en = 1'b1;
    int          sub_cnt = 0;
    int          edges = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
        return {4'(op), 3'(rd), 3'(rs1), 3'(rs2), 3'b000};
    endfunction

    function automatic logic [15:0] enc_i(input int op, input int rd, input int imm);
        return {4'(op), 3'(rd), 1'b0, 8'(imm)};
    endfunction

    task automatic clear_mem();
        foreach (mem[i]) mem[i] = HALT_INS;
    endtask

    // Program-level model: run from PC 0 until HALT, one record per retire
    task automatic build_model();
        int r[8];
        int pc, op, rd, rs1, rs2, imm, res;
        bit wr;
        logic [15:0] ins;
        exp_t e;
        foreach (r[i]) r[i] = 0;
        pc = 0;
        for (int s = 0; s < 1000; s++) begin
            ins = mem[pc];
            op  = int'(ins[15:12]);
            rd  = int'(ins[11:9]);
            rs1 = int'(ins[8:6]);
            rs2 = int'(ins[5:3]);
            imm = int'(ins[7:0]);
            wr  = 1'b1;
            res = 0;
            e.pc = pc;
            pc = (pc + 1) % 256;
            case (op)
                0: res = (r[rs1] + r[rs2]) & MASK;
                1: res = (r[rs1] - r[rs2]) & MASK;
                2: res = r[rs1] & r[rs2];
                3: res = r[rs1] | r[rs2];
                4: res = r[rs1] ^ r[rs2];
                5: res = (r[rs1] * 2) & MASK;
                6: res = r[rs1] / 2;
                7: res = r[rs1];
                8: res = imm & MASK;
                9: begin wr = 1'b0; if (r[rd] == 0) pc = imm; end
                10: begin wr = 1'b0; pc = imm; end
                default: wr = 1'b0;
            endcase
            if (wr && !(R0Z && rd == 0)) r[rd] = res;
            e.rd  = rd;
            e.val = r[rd];
            exp_q.push_back(e);
            if (op == 15) break;
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) edges = 0;
        else edges++;
    end

    // Instruction memory responder with stall injection
    initial begin
        int left;
        int st;
        int cur_addr;
        acc_t a;
        left = -1;
        st = 0;
        cur_addr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                left = -1;
                imem_valid = 1'b0;
            end else if (imem_req) begin
                if (left < 0) begin
                    case (stall_mode)
                        0: st = 0;
                        1: st = 3;
                        default: st = $urandom_range(0, 3);
                    endcase
                    left = st;
                    cur_addr = int'(imem_addr);
                end else begin
                    check("addr_stable", int'(imem_addr), cur_addr);
                end
                if (left == 0) begin
                    imem_valid = 1'b1;
                    imem_data  = mem[imem_addr];
                    a.addr = cur_addr;
                    a.stall = st;
                    acc_q.push_back(a);
                    left = -1;
                end else begin
                    imem_valid = 1'b0;
                    imem_data  = 16'($urandom);
                    left--;
                end
            end else begin
                if (left >= 0) begin
                    check("req_held", int'(imem_req), 1);
                    left = -1;
                end
                // Noise outside FETCH must be ignored
                imem_valid = 1'($urandom_range(0, 1));
                imem_data  = 16'($urandom);
            end
        end
    end

    // Monitor: pops expectations on each retire
    initial begin
        int last;
        bit first;
        bit pend;
        int pend_rd, pend_val;
        exp_t e;
        acc_t a;
        last = 0;
        first = 1'b1;
        pend = 1'b0;
        pend_rd = 0;
        pend_val = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last = 0;
                first = 1'b1;
                pend = 1'b0;
            end else begin
                if (pend) begin
                    dbg_raddr = 3'(pend_rd);
                    #1;
                    check("reg_after_retire", int'(dbg_rdata), pend_val);
                    pend = 1'b0;
                end
                if (retire && sb_en) begin
                    if (exp_q.size() == 0) begin
                        check("extra_retire", int'(retire), 0);
                    end else if (acc_q.size() == 0) begin
                        check("retire_without_fetch", int'(retire), 0);
                        void'(exp_q.pop_front());
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        check("retire_pc", a.addr, e.pc);
                        check("retire_gap", edges - last, (first ? 1 : 2) + a.stall);
                        if (a.addr == 2) sub_cnt++;
                        pend = 1'b1;
                        pend_rd = e.rd;
                        pend_val = e.val;
                    end
                    last = edges;
                    first = 1'b0;
                end
            end
        end
    end

    task automatic read_reg(input int idx, output int val);
        @(negedge clk);
        dbg_raddr = 3'(idx);
        #1;
        val = int'(dbg_rdata);
    endtask

    task automatic start_test(input int mode);
        rst_n = 1'b0;
        sb_en = 1'b1;
        stall_mode = mode;
        repeat (2) @(posedge clk);
        #1;
        check("rst_halted", int'(halted), 0);
        check("rst_retire", int'(retire), 0);
        check("rst_req", int'(imem_req), 1);
        check("rst_addr", int'(imem_addr), 0);
        exp_q.delete();
        acc_q.delete();
        sub_cnt = 0;
        build_model();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_halt();
        for (int i = 0; i < 3000 && !halted; i++) @(negedge clk);
        if (!halted) check("halt_timeout", int'(halted), 1);
    endtask

    task automatic finish_test();
        wait_halt();
        repeat (3) @(negedge clk);
        check("all_retired", exp_q.size(), 0);
        check("halted", int'(halted), 1);
        check("req_low_halt", int'(imem_req), 0);
    endtask

    task automatic load_basic();
        clear_mem();
        mem[0] = enc_i(8, 1, 5);
        mem[1] = enc_i(8, 2, 3);
        mem[2] = enc_r(0, 3, 1, 2);
        mem[3] = HALT_INS;
    endtask

    initial begin
        int v;
        bit found;
        int len, op;

        // Zero-wait basic program
        load_basic();
        start_test(0);
        finish_test();
        read_reg(3, v); check("basic_r3", v, 8);

        // Same program with 3-cycle fetch stalls
        load_basic();
        start_test(1);
        finish_test();
        read_reg(3, v); check("stall_r3", v, 8);

        // Wrap-around arithmetic
        clear_mem();
        mem[0] = enc_i(8, 1, 255);
        mem[1] = enc_i(8, 2, 1);
        mem[2] = enc_r(0, 3, 1, 2);
        mem[3] = enc_r(1, 4, 3, 2);
        start_test(2);
        finish_test();
        read_reg(3, v); check("wrap_r3", v, 0);
        read_reg(4, v); check("wrap_r4", v, 255);

        // Countdown loop
        clear_mem();
        mem[0] = enc_i(8, 1, 3);
        mem[1] = enc_i(8, 2, 1);
        mem[2] = enc_r(1, 1, 1, 2);
        mem[3] = enc_i(9, 1, 5);
        mem[4] = enc_i(10, 0, 2);
        start_test(2);
        finish_test();
        check("loop_sub_count", sub_cnt, 3);
        read_reg(1, v); check("loop_r1", v, 0);

        // Reset during EXEC of the ADD
        load_basic();
        start_test(0);
        sb_en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (retire && imem_addr == 8'd2) found = 1'b1;
        end
        check("abort_reached_add", int'(found), 1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_retire", int'(retire), 0);
        dbg_raddr = 3'd3; #1;
        check("abort_r3", int'(dbg_rdata), 0);
        dbg_raddr = 3'd1; #1;
        check("abort_r1", int'(dbg_rdata), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("abort_addr", int'(imem_addr), 0);
        check("abort_req", int'(imem_req), 1);
        wait_halt();
        read_reg(3, v); check("abort_rerun_r3", v, 8);

        // r0 write behaviour
        clear_mem();
        mem[0] = enc_i(8, 0, 7);
        start_test(0);
        finish_test();
        read_reg(0, v); check("r0_write", v, R0Z ? 0 : 7);

        // Random forward-branching programs with random stalls
        for (int t = 0; t < 15; t++) begin
            clear_mem();
            len = $urandom_range(8, 40);
            for (int i = 0; i < len; i++) begin
                op = $urandom_range(0, 14);
                if (op == 9 || op == 10)
                    mem[i] = enc_i(op, $urandom_range(0, 7), $urandom_range(i + 1, len));
                else
                    mem[i] = {4'(op), 12'($urandom)};
            end
            mem[len] = HALT_INS;
            start_test(2);
            finish_test();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
